// File: rtl/div_rem_seq_pkg.sv
// Shared types and sizing helpers for the iterative RV32M divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
    typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_t;

    function automatic int cnt_w(input int dw);
        return $clog2(dw) + 1;
    endfunction

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = cnt_w(DIV_WIDTH);

endpackage

// File: rtl/div_rem_seq_if.sv
// Start/busy/done handshake and operand/result bundle between execute stage and divider.
interface div_rem_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  kill;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] operand_1;
    logic [DATA_WIDTH-1:0] operand_2;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output start, kill, op, operand_1, operand_2,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, kill, op, operand_1, operand_2,
        output ready, busy, done, result
    );
endinterface

// File: rtl/div_rem_seq_step.sv
// One restoring division iteration: shift {rem,quo} left and subtract the divisor if it fits.
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] quo_o
);
    logic [DATA_WIDTH:0] rem_shifted;
    logic [DATA_WIDTH:0] trial;

    assign rem_shifted = {rem_i, quo_i[DATA_WIDTH-1]};
    assign trial       = rem_shifted - {1'b0, divisor_i};

    always_comb begin
        rem_o = rem_shifted[DATA_WIDTH-1:0];
        quo_o = {quo_i[DATA_WIDTH-2:0], 1'b0};
        if (!trial[DATA_WIDTH]) begin
            rem_o = trial[DATA_WIDTH-1:0];
            quo_o = {quo_i[DATA_WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_rem_seq.sv
// Iterative radix-2 restoring DIV/DIVU/REM/REMU unit with start/busy/done handshake.
// Define DIV_SPECIAL_FAST_EN to resolve divide-by-zero and signed overflow in one cycle.
module div_rem_seq
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int END_IDX    = DATA_WIDTH - 1
) (
    input logic         clk,
    input logic         reset,
    div_rem_seq_if.slave bus
);
    localparam int CNT_W = cnt_w(DATA_WIDTH);

    div_state_t            state_q, state_d;
    div_op_t               op_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [END_IDX:0]      rem_q, quo_q, dvs_q, result_q;
    logic                  neg_quo_q, neg_rem_q, div_zero_q;

    logic                  accept, signed_op, op1_neg, op2_neg;
    logic                  in_zero, in_ovf, fast_special, final_step;
    logic [END_IDX:0]      op1_abs, op2_abs, special_res;
    logic [END_IDX:0]      step_rem, step_quo, quo_fix, rem_fix, final_res;

    assign accept    = (state_q == IDLE) && bus.start && !bus.kill;
    assign signed_op = !bus.op[0];
    assign op1_neg   = signed_op && bus.operand_1[END_IDX];
    assign op2_neg   = signed_op && bus.operand_2[END_IDX];
    assign op1_abs   = op1_neg ? -bus.operand_1 : bus.operand_1;
    assign op2_abs   = op2_neg ? -bus.operand_2 : bus.operand_2;
    assign in_zero   = (bus.operand_2 == '0);
    assign in_ovf    = signed_op && (bus.operand_1 == {1'b1, {END_IDX{1'b0}}}) && (&bus.operand_2);

`ifdef DIV_SPECIAL_FAST_EN
    assign fast_special = in_zero || in_ovf;
`else
    assign fast_special = 1'b0;
`endif

    always_comb begin
        if (in_zero) special_res = bus.op[1] ? bus.operand_1 : '1;
        else         special_res = bus.op[1] ? '0 : bus.operand_1;
    end

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Signed overflow falls out of the normal fix-up; only divide-by-zero needs a forced quotient.
    assign quo_fix    = div_zero_q ? '1 : (neg_quo_q ? -step_quo : step_quo);
    assign rem_fix    = neg_rem_q ? -step_rem : step_rem;
    assign final_res  = ((op_q == REM) || (op_q == REMU)) ? rem_fix : quo_fix;
    assign final_step = (state_q == CALC) && !bus.kill && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = fast_special ? DONE : CALC;
            CALC:    if (bus.kill) state_d = IDLE;
                     else if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // done is masked by kill in the DONE cycle so a flushed instruction never retires.
    always_comb begin
        bus.ready  = (state_q == IDLE);
        bus.busy   = (state_q != IDLE);
        bus.done   = (state_q == DONE) && !bus.kill;
        bus.result = result_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= DIV;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            result_q   <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (accept) begin
            op_q       <= div_op_t'(bus.op);
            neg_quo_q  <= op1_neg ^ op2_neg;
            neg_rem_q  <= op1_neg;
            div_zero_q <= in_zero;
            quo_q      <= op1_abs;
            dvs_q      <= op2_abs;
            rem_q      <= '0;
            cnt_q      <= fast_special ? '0 : CNT_W'(DATA_WIDTH);
            if (fast_special) result_q <= special_res;
        end else if (state_q == CALC) begin
            if (bus.kill) begin
                cnt_q <= '0;
            end else begin
                rem_q <= step_rem;
                quo_q <= step_quo;
                cnt_q <= cnt_q - CNT_W'(1);
                if (final_step) result_q <= final_res;
            end
        end
    end
endmodule
